instr_encoder: RTL and testbench

//  Inverse of the main control decoder: assembles RV32I instruction words from

---
 rtl/instr_encoder.sv | 156 +++++++++++++++
 tb/tb_instr_encoder.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I instruction words from field requests and
// streams them with an incrementing word address toward the instruction-memory
// loader. One-deep registered output stage with valid/ready on both sides.
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not
// fit their instruction field (the truncated word is still emitted).

module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    output logic              full
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic {RUN, FULL} encState;

    encState           state;
    encState           stateNext;
    logic              outValidR;
    logic [31:0]       outInstrR;
    logic [ADDR_W-1:0] outAddrR;
    logic              outErrR;
    logic              errStickyR;
    logic [ADDR_W-1:0] nextAddr;
    logic              accept;
    logic [32:0]       encoded;

    // Returns {err, instr}; err marks an illegal kind or an unrepresentable immediate.
    function automatic logic [32:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [31:0] instr;
        logic        err;
        logic        isShift;
`ifdef IMM_RANGE_CHECK_EN
        logic signed [31:0] simm;
        logic               rangeBad;
`endif
        instr   = NOP_WORD;
        err     = 1'b0;
        isShift = (f3 == 3'b001) || (f3 == 3'b101);
        case (kind)
            4'd0: instr = {imm[11:0], rs1, f3, rd, OP_LOAD};
            4'd1: instr = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            4'd2: instr = {f7, rs2, rs1, f3, rd, OP_REG};
            4'd3: instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            4'd4: instr = isShift ? {f7, imm[4:0], rs1, f3, rd, OP_IMM}
                                  : {imm[11:0], rs1, f3, rd, OP_IMM};
            4'd5: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            4'd6: instr = {imm[31:12], rd, OP_AUIPC};
            4'd7: instr = {imm[31:12], rd, OP_LUI};
            4'd8: instr = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            default: err = 1'b1;
        endcase
`ifdef IMM_RANGE_CHECK_EN
        simm     = imm;
        rangeBad = 1'b0;
        case (kind)
            4'd0, 4'd1, 4'd8: rangeBad = (simm < -32'sd2048) || (simm > 32'sd2047);
            4'd3: rangeBad = (simm < -32'sd4096) || (simm > 32'sd4095) || imm[0];
            4'd4: rangeBad = isShift ? (imm > 32'd31)
                                     : ((simm < -32'sd2048) || (simm > 32'sd2047));
            4'd5: rangeBad = (simm < -32'sd1048576) || (simm > 32'sd1048575) || imm[0];
            4'd6, 4'd7: rangeBad = (imm[11:0] != 12'd0);
            default: rangeBad = 1'b0;
        endcase
        err = err | rangeBad;
`endif
        return {err, instr};
    endfunction

    assign in_ready = (state == RUN) & ~clear & (~outValidR | out_ready);
    assign accept   = in_valid & in_ready;
    assign encoded  = encode(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

    // Capacity state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= stateNext;
    end

    // Clear restarts; consuming the last address parks the encoder in FULL.
    always_comb begin
        stateNext = state;
        if (clear)                        stateNext = RUN;
        else if (accept && nextAddr == '1) stateNext = FULL;
    end

    // Output holding register, address counter and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValidR  <= 1'b0;
            outInstrR  <= 32'd0;
            outAddrR   <= '0;
            outErrR    <= 1'b0;
            errStickyR <= 1'b0;
            nextAddr   <= '0;
        end else if (clear) begin
            outValidR  <= 1'b0;
            outAddrR   <= '0;
            outErrR    <= 1'b0;
            errStickyR <= 1'b0;
            nextAddr   <= '0;
        end else if (accept) begin
            outValidR  <= 1'b1;
            outInstrR  <= encoded[31:0];
            outErrR    <= encoded[32];
            outAddrR   <= nextAddr;
            nextAddr   <= nextAddr + 1'b1;
            errStickyR <= errStickyR | encoded[32];
        end else if (out_ready) begin
            outValidR  <= 1'b0;
        end
    end

    assign out_valid  = outValidR;
    assign out_instr  = outInstrR;
    assign out_addr   = outAddrR;
    assign out_err    = outErrR;
    assign err_sticky = errStickyR;
    assign full       = (state == FULL);

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed words, back-pressure,
// capacity exhaustion and randomized traffic against a field-level model.
// Build with IMM_RANGE_CHECK_EN defined to exercise the range-check variant.

module tb_instr_encoder;

    localparam int AW = 10;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, clear, in_valid, in_ready;
    logic [3:0]    in_kind;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          out_valid, out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err, err_sticky, full;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        logic          err;
    } wordT;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky), .full(full)
    );

    always #5 clk = ~clk;

    // Field-level model: builds the word arithmetically and judges ranges numerically.
    function automatic logic [32:0] refEncode(int kind, int rd, int rs1, int rs2,
                                              int f3, int f7, int imm);
        int w;
        bit e;
        bit bad;
        e = 0;
        bad = 0;
        case (kind)
            0: begin w = ((imm & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h03;
                     bad = imm < -2048 || imm > 2047; end
            1: begin w = (((imm >>> 5) & 'h7F) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                         + ((imm & 31) << 7) + 'h23;
                     bad = imm < -2048 || imm > 2047; end
            2: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h33;
            3: begin w = (((imm >>> 12) & 1) << 31) + (((imm >>> 5) & 63) << 25) + (rs2 << 20)
                         + (rs1 << 15) + (f3 << 12) + (((imm >>> 1) & 15) << 8)
                         + (((imm >>> 11) & 1) << 7) + 'h63;
                     bad = imm < -4096 || imm > 4095 || (imm % 2) != 0; end
            4: if (f3 == 1 || f3 == 5) begin
                   w = (f7 << 25) + ((imm & 31) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
                   bad = imm < 0 || imm > 31;
               end else begin
                   w = ((imm & 'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 'h13;
                   bad = imm < -2048 || imm > 2047;
               end
            5: begin w = (((imm >>> 20) & 1) << 31) + (((imm >>> 1) & 'h3FF) << 21)
                         + (((imm >>> 11) & 1) << 20) + (((imm >>> 12) & 'hFF) << 12)
                         + (rd << 7) + 'h6F;
                     bad = imm < -1048576 || imm > 1048575 || (imm % 2) != 0; end
            6: begin w = (imm & 'hFFFFF000) + (rd << 7) + 'h17; bad = (imm & 'hFFF) != 0; end
            7: begin w = (imm & 'hFFFFF000) + (rd << 7) + 'h37; bad = (imm & 'hFFF) != 0; end
            8: begin w = ((imm & 'hFFF) << 20) + (rs1 << 15) + (rd << 7) + 'h67;
                     bad = imm < -2048 || imm > 2047; end
            default: begin w = 'h13; e = 1; end
        endcase
        if (RC) e = e | bad;
        return {e, w};
    endfunction

    task automatic setReq(input int k, input int rd, input int rs1, input int rs2,
                          input int f3, input int f7, input int imm);
        in_valid  = 1'b1;
        in_kind   = 4'(k);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 32'(imm);
    endtask

    task automatic pulseClear();
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_blocks_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || err_sticky !== 1'b0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL after_clear: got valid %b sticky %b full %b expected 0 0 0",
                     out_valid, err_sticky, full);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear = 1'b0;
        out_ready = 1'b0;
        setReq(2, 1, 2, 3, 0, 0, 0);
        repeat (2) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_addr !== '0 || out_err !== 1'b0
            || err_sticky !== 1'b0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got valid %b instr %h addr %0d err %b sticky %b full %b expected all 0",
                     out_valid, out_instr, out_addr, out_err, err_sticky, full);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_encode();
        int kinds[5] = '{0, 1, 3, 5, 15};
        int rds[5]   = '{5, 0, 0, 1, 0};
        int rs1s[5]  = '{2, 2, 1, 0, 0};
        int rs2s[5]  = '{0, 6, 2, 0, 0};
        int f3s[5]   = '{2, 2, 0, 0, 0};
        int imms[5]  = '{8, 12, -4, 'h800, 0};
        logic [31:0] expW[5] = '{32'h00812283, 32'h00612623, 32'hFE208EE3, 32'h001000EF, 32'h00000013};
        logic expE[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            setReq(kinds[i], rds[i], rs1s[i], rs2s[i], f3s[i], 0, imms[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_instr !== expW[i] || out_addr !== AW'(i)
                || out_err !== expE[i]) begin
                miscompares++;
                $display("FAIL encode_%0d: got v%b %h @%0d e%b expected v1 %h @%0d e%b",
                         i, out_valid, out_instr, out_addr, out_err, expW[i], i, expE[i]);
            end
            vectors++;
            if (err_sticky !== expE[i]) begin
                miscompares++;
                $display("FAIL sticky_%0d: got %b expected %b", i, err_sticky, expE[i]);
            end
        end
    endtask

    task automatic test_range();
        int kinds[4] = '{4, 3, 4, 7};
        int f3s[4]   = '{0, 0, 1, 0};
        int f7s[4]   = '{0, 0, 'h20, 0};
        int rds[4]   = '{1, 0, 3, 7};
        int rs1s[4]  = '{0, 0, 4, 0};
        int imms[4]  = '{2048, 3, 5, 'h12345000};
        logic [31:0] expW[4] = '{32'h80000093, 32'h00000163, 32'h40521193, 32'h123453B7};
        logic expE[4] = '{RC, RC, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            setReq(kinds[i], rds[i], rs1s[i], 0, f3s[i], f7s[i], imms[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_instr !== expW[i] || out_err !== expE[i]) begin
                miscompares++;
                $display("FAIL range_%0d: got v%b %h e%b expected v1 %h e%b",
                         i, out_valid, out_instr, out_err, expW[i], expE[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        pulseClear();
        @(posedge clk); #1;
        out_ready = 1'b0;
        setReq(0, 5, 2, 0, 2, 0, 8);
        @(posedge clk); #1;
        setReq(1, 0, 2, 6, 2, 0, 12);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_instr !== 32'h00812283 || out_addr !== '0
                || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_%0d: got v%b %h @%0d rdy %b expected v1 00812283 @0 rdy 0",
                         c, out_valid, out_instr, out_addr, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_instr !== 32'h00812283 || out_addr !== '0) begin
            miscompares++;
            $display("FAIL release: got rdy %b %h @%0d expected rdy 1 00812283 @0",
                     in_ready, out_instr, out_addr);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_instr !== 32'h00612623 || out_addr !== AW'(1)) begin
            miscompares++;
            $display("FAIL second_word: got v%b %h @%0d expected v1 00612623 @1",
                     out_valid, out_instr, out_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drained: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_random(input int n);
        wordT q[$];
        wordT w;
        logic [32:0] r;
        int  expNext;
        bit  expSticky;
        bit  hadWord;
        bit  expReady;
        int  imm;
        pulseClear();
        expNext = 0;
        expSticky = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0: imm = int'($urandom_range(0, 4095)) - 2048;
                1: imm = int'($urandom_range(0, 8191)) - 4096;
                2: imm = int'($urandom);
                default: imm = int'($urandom_range(0, 40));
            endcase
            setReq(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 127)), imm);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hadWord = (q.size() != 0);
            vectors++;
            if (out_valid !== hadWord || err_sticky !== expSticky) begin
                miscompares++;
                $display("FAIL rnd_state_%0d: got v%b sticky %b expected v%b sticky %b",
                         i, out_valid, err_sticky, hadWord, expSticky);
            end
            if (hadWord) begin
                vectors++;
                if (out_instr !== q[0].instr || out_addr !== q[0].addr || out_err !== q[0].err) begin
                    miscompares++;
                    $display("FAIL rnd_word_%0d: got %h @%0d e%b expected %h @%0d e%b",
                             i, out_instr, out_addr, out_err, q[0].instr, q[0].addr, q[0].err);
                end
                if (out_ready) void'(q.pop_front());
            end
            expReady = !hadWord || out_ready;
            vectors++;
            if (in_ready !== expReady) begin
                miscompares++;
                $display("FAIL rnd_ready_%0d: got %b expected %b", i, in_ready, expReady);
            end
            if (in_valid && expReady) begin
                r = refEncode(int'(in_kind), int'(in_rd), int'(in_rs1), int'(in_rs2),
                              int'(in_funct3), int'(in_funct7), int'($signed(in_imm)));
                w.instr = r[31:0];
                w.err = r[32];
                w.addr = AW'(expNext);
                q.push_back(w);
                expNext++;
                expSticky = expSticky | r[32];
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_full();
        int drops;
        pulseClear();
        out_ready = 1'b1;
        drops = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            @(posedge clk); #1;
            setReq(2, 1, 2, 3, 0, 0, 0);
            @(negedge clk);
            if (in_ready !== 1'b1 || full !== 1'b0) drops++;
        end
        vectors++;
        if (drops != 0) begin
            miscompares++;
            $display("FAIL fill_ready: got %0d stalled cycles expected 0", drops);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (full !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_addr !== AW'((1 << AW) - 1)) begin
            miscompares++;
            $display("FAIL full_last: got full %b rdy %b v%b @%0d expected 1 0 1 @%0d",
                     full, in_ready, out_valid, out_addr, (1 << AW) - 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (full !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_drain: got full %b rdy %b v%b expected 1 0 0", full, in_ready, out_valid);
        end
        pulseClear();
        @(posedge clk); #1;
        setReq(0, 5, 2, 0, 2, 0, 8);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_addr !== '0 || out_instr !== 32'h00812283) begin
            miscompares++;
            $display("FAIL restart_word: got v%b %h @%0d expected v1 00812283 @0",
                     out_valid, out_instr, out_addr);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_reset: got v%b %h full %b expected 0 0 0",
                     out_valid, out_instr, full);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_encode();
        test_range();
        test_back_to_back();
        test_random(400);
        test_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
